// File: rtl/pbit_sampler.sv
// pbit_sampler: stochastic p-bit update, p = sgn(tanh(I) - r).
// IDLE/SAMPLE/COMMIT sequence fed by a free-running Fibonacci LFSR.
module pbit_sampler #(
  parameter int unsigned          IN_PRECISION = 6,
  parameter int unsigned          RNG_WIDTH    = 16,
  parameter logic [RNG_WIDTH-1:0] SEED         = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_PRECISION-1:0] I_in,
  input  logic                    update_req,
  input  logic                    seed_load,
  input  logic [RNG_WIDTH-1:0]    seed_in,
  output logic                    p_out,
  output logic                    p_valid,
  output logic                    busy,
  output logic [15:0]             flip_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [RNG_WIDTH-1:0]    r_lfsr;
  logic [RNG_WIDTH-1:0]    w_lfsr_next;
  logic                    w_fb;
  logic [IN_PRECISION-1:0] r_i;
  logic [IN_PRECISION-1:0] w_neg;
  logic [7:0]              r_r;
  logic [7:0]              r_t;
  logic [7:0]              w_t;
  logic                    w_p;
  logic                    r_p;
  logic                    r_valid;
  logic [15:0]             r_flip_count;

  // round(127*tanh(m/8)) for m = 0..31
  function automatic logic [7:0] tanh_pos(input logic [4:0] m);
    case (m)
      5'd0:    return 8'd0;
      5'd1:    return 8'd16;
      5'd2:    return 8'd31;
      5'd3:    return 8'd46;
      5'd4:    return 8'd59;
      5'd5:    return 8'd70;
      5'd6:    return 8'd81;
      5'd7:    return 8'd89;
      5'd8:    return 8'd97;
      5'd9:    return 8'd103;
      5'd10:   return 8'd108;
      5'd11:   return 8'd112;
      5'd12:   return 8'd115;
      5'd13:   return 8'd118;
      5'd14:   return 8'd120;
      5'd15:   return 8'd121;
      5'd16:   return 8'd122;
      5'd17:   return 8'd123;
      5'd18:   return 8'd124;
      5'd19:   return 8'd125;
      5'd20:   return 8'd125;
      5'd21:   return 8'd126;
      5'd22:   return 8'd126;
      5'd23:   return 8'd126;
      5'd24:   return 8'd126;
      default: return 8'd127;
    endcase
  endfunction

  // Negative inputs mirror the positive half; -32 has no positive twin.
  always_comb begin
    w_neg = -r_i;
    w_t   = tanh_pos(r_i[4:0]);
    if (r_i[IN_PRECISION-1]) begin
      if (w_neg[IN_PRECISION-1]) begin
        w_t = 8'h81;
      end else begin
        w_t = -tanh_pos(w_neg[4:0]);
      end
    end
  end

  assign w_p = $signed(r_t) > $signed(r_r);

  assign w_fb = r_lfsr[15] ^ r_lfsr[13]
              ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    w_lfsr_next = {r_lfsr[RNG_WIDTH-2:0], w_fb};
    if (seed_load) begin
      if (seed_in == '0) begin
        w_lfsr_next = SEED;
      end else begin
        w_lfsr_next = seed_in;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (update_req) w_next = SAMPLE;
      SAMPLE:  w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lfsr       <= SEED;
      r_i          <= '0;
      r_r          <= '0;
      r_t          <= '0;
      r_p          <= 1'b0;
      r_valid      <= 1'b0;
      r_flip_count <= '0;
    end else begin
      r_state <= w_next;
      r_lfsr  <= w_lfsr_next;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (update_req) begin
            r_i <= I_in;
            r_r <= r_lfsr[7:0];
          end
        end
        SAMPLE: r_t <= w_t;
        COMMIT: begin
          r_p     <= w_p;
          r_valid <= 1'b1;
          if (w_p != r_p && r_flip_count != 16'hFFFF) begin
            r_flip_count <= r_flip_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign p_out      = r_p;
  assign p_valid    = r_valid;
  assign busy       = (r_state != IDLE);
  assign flip_count = r_flip_count;

endmodule

// File: doc/pbit_sampler.md
# pbit_sampler

Stochastic p-bit update stage: consumes the signed, saturated synaptic input I produced by the p-bit MAC and returns the p-bit state that drives the neighbours' MAC inputs. On each accepted update request it evaluates p = sgn(tanh(I) − r). Here r is a uniform pseudo-random number from an internal LFSR. The result is registered as the p-bit output, with 1 meaning +1 and 0 meaning −1. One instance sits beside each MAC in the ripple-adder p-bit network.

## Interface
- IN_PRECISION, 6, width of signed input I, two's complement; fixed-point scale is I/8.
- RNG_WIDTH, 16, LFSR width; the polynomial below is defined only for 16.
- SEED, 16'hACE1, LFSR value after reset and substitute for a zero seed.
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  synchronous, active-high reset.
- I_in  in  IN_PRECISION  signed input current from the MAC; sampled only when a request is accepted.
- update_req  in  1  single-cycle request to resample p; accepted only when busy=0.
- seed_load  in  1  load seed_in into the LFSR at this edge.
- seed_in  in  RNG_WIDTH  new LFSR seed.
- p_out  out  1  current p-bit state; held between updates.
- p_valid  out  1  one-cycle pulse when p_out has just been updated.
- busy  out  1  high while an update is in flight.
- flip_count  out  16  number of committed updates that changed p_out; saturates at 16'hFFFF.

## Operation
- LFSR:
  - Fibonacci, free-running, advances every clock.
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - If seed_load=1, the LFSR loads seed_in instead; seed_in=0 loads SEED.
- Random sample: r = $signed(lfsr[7:0]), range −128..127. It is taken from the LFSR register value present at the accept edge, before that edge's shift or load.
- tanh LUT:
  - 64-entry constant table, t = round(127·tanh(I/8)), signed 8 bit.
  - Anchor entries: I=0→0, 8→97, −8→−97, 31→127, −32→−127.
  - Odd-symmetric for I in −31..31.
- Decision: p = ($signed(t) > $signed(r)), compared as signed 8 bit.
- FSM states: IDLE, SAMPLE, COMMIT.
  - IDLE: on update_req=1, capture I_in and r and go to SAMPLE. Otherwise stay.
  - SAMPLE: register t from the LUT lookup of the captured I, and hold r. Go to COMMIT.
  - COMMIT: write p_out := p and pulse p_valid. If p differs from the old p_out, increment flip_count, saturating. Go to IDLE.
- update_req is ignored in SAMPLE and COMMIT; it is not queued.
- Reset, at any state including mid-update:
  - State goes to IDLE and the in-flight update is discarded.
  - p_out=0, p_valid=0, busy=0, flip_count=0, lfsr=SEED.
  - rst has priority over seed_load and update_req.
- seed_load together with an accepted update_req: r uses the pre-load LFSR value; the load takes effect at the same edge.

## Timing
- Request sampled at edge k (state IDLE) → SAMPLE after edge k → COMMIT after edge k+1.
- p_out updates and p_valid=1 after edge k+2. p_valid drops after edge k+3.
- busy=1 after edges k and k+1, busy=0 after edge k+2. A new request is therefore accepted at edge k+3 at the earliest, i.e. at most one update per 3 cycles.
- All outputs are registered; there are no combinational paths from input to output.
- I_in may change after the accept edge without affecting the result.

## Test plan
- Reset, then update_req with I_in=0 at the first post-reset edge: r = 8'hE1 = −31 and t = 0. Required: p_out=1 and p_valid pulse exactly 2 edges later; flip_count=1.
- After reset, the LFSR sequence from 16'hACE1 is 16'h59C3 after 1 clock. seed_load with seed_in=0 → lfsr=16'hACE1 on the next cycle. seed_load with seed_in=16'h1234 → lfsr=16'h1234.
- 4096 updates with I_in=−32: required p_out=1 at most 20 times (expected ≈ 1/256). 4096 updates with I_in=31: p_out=0 at most 20 times.
- 8192 updates each at I_in=8 and I_in=−8: fraction of p_out=1 within 0.88±0.03 and 0.12±0.03 respectively (theory (1+tanh(I/8))/2).
- update_req held high continuously: p_valid pulses every 3rd cycle; no pulse is lost or duplicated; busy pattern is 1,1,0 repeating.
- rst asserted in SAMPLE and again in COMMIT: no p_valid pulse, p_out=0, flip_count=0. The next request completes normally with 2-edge latency.
- Force 65536+ alternating flips (toggle I_in between −32 and 31): flip_count saturates at 16'hFFFF and does not wrap.
